// File: rtl/cnn_buffer_pkg.sv
// Shared types and constants for the layer2 -> pooling frame buffer.
// Channel geometry, buffer FSM states and the parity-bank selector.
package cnn_buffer_pkg;

    localparam int CH_N       = 8;
    localparam int CH_W       = 16;
    localparam int DATA_W     = CH_N * CH_W;
    localparam int WORDLENGTH = 16;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DONE  = 2'd1,
        SERVE = 2'd2
    } buf_state_e;

    // Bank index {row parity, col parity}: 0=ee, 1=eo, 2=oe, 3=oo
    function automatic logic [1:0] bank_sel(input logic row_lsb, input logic col_lsb);
        return {row_lsb, col_lsb};
    endfunction

endpackage

// File: rtl/pixel_bank.sv
// One parity bank: single write port, registered read port, read-before-write.
// Storage and read register carry data only, so neither is reset.
module pixel_bank #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 128
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata_p1
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_p1 <= mem[raddr];
        end
    end

endmodule

// File: rtl/layer2_pixel_buffer_2x2.sv
// Frame buffer between layer2 convolution and 2x2 max-pooling; four parity banks.
// Optional macro BUFFER_RELU_EN clamps negative channels to zero on write.
module layer2_pixel_buffer_2x2
    import cnn_buffer_pkg::*;
#(
    parameter int IN_DIM = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [WORDLENGTH-1:0] write_row,
    input  logic [WORDLENGTH-1:0] write_col,
    input  logic [DATA_W-1:0]     write_data,
    input  logic                  layer2_calculation_done,
    input  logic                  read_pixel_signal,
    input  logic [WORDLENGTH-1:0] read_row_addr,
    input  logic [WORDLENGTH-1:0] read_col_addr,
    input  logic                  layer3_calculation_done,
    output logic [DATA_W-1:0]     output_data_even_even,
    output logic [DATA_W-1:0]     output_data_even_odd,
    output logic [DATA_W-1:0]     output_data_odd_even,
    output logic [DATA_W-1:0]     output_data_odd_odd,
    output logic                  pixel_store_done,
    output logic                  write_error
);

    localparam int HALF      = IN_DIM / 2;
    localparam int DEPTH     = HALF * HALF;
    localparam int AW        = $clog2(DEPTH);
    localparam int FRAME_PIX = IN_DIM * IN_DIM;
    localparam int CNT_W     = $clog2(FRAME_PIX + 1);

    buf_state_e         state;
    logic [CNT_W-1:0]   store_count;
    logic [CNT_W-1:0]   count_next;
    logic               l2_seen;

    logic               wr_in_range;
    logic               wr_ok;
    logic [1:0]         wbank;
    logic [AW-1:0]      waddr;
    logic [DATA_W-1:0]  wdata_p0;
    logic               rd_in_range;
    logic               rd_req;
    logic [AW-1:0]      raddr;
    logic               rd_zero_p1;
    logic [DATA_W-1:0]  rdata_p1 [4];

`ifdef BUFFER_RELU_EN
    function automatic logic [DATA_W-1:0] relu_word(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        logic signed [CH_W-1:0] ch;
        r = '0;
        for (int k = 0; k < CH_N; k++) begin
            ch = d[k*CH_W +: CH_W];
            r[k*CH_W +: CH_W] = (ch < 0) ? '0 : ch;
        end
        return r;
    endfunction
    assign wdata_p0 = relu_word(write_data);
`else
    assign wdata_p0 = write_data;
`endif

    // Write decode: parity picks the bank, halved coordinates pick the word
    assign wr_in_range = (write_row < WORDLENGTH'(IN_DIM)) && (write_col < WORDLENGTH'(IN_DIM));
    assign wr_ok       = write_enable && wr_in_range && (state == FILL);
    assign wbank       = bank_sel(write_row[0], write_col[0]);
    assign waddr       = AW'((write_row >> 1) * WORDLENGTH'(HALF) + (write_col >> 1));

    assign rd_in_range = (read_row_addr < WORDLENGTH'(HALF)) && (read_col_addr < WORDLENGTH'(HALF));
    assign rd_req      = read_pixel_signal && rd_in_range;
    assign raddr       = AW'(read_row_addr * WORDLENGTH'(HALF) + read_col_addr);

    assign count_next  = (wr_ok && (store_count != CNT_W'(FRAME_PIX))) ? store_count + 1'b1
                                                                       : store_count;

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_bank
            pixel_bank #(
                .DEPTH (DEPTH),
                .AW    (AW),
                .DW    (DATA_W)
            ) u_bank (
                .clk      (clk),
                .we       (wr_ok && (wbank == 2'(b))),
                .waddr    (waddr),
                .wdata    (wdata_p0),
                .re       (rd_req),
                .raddr    (raddr),
                .rdata_p1 (rdata_p1[b])
            );
        end
    endgenerate

    // p1: an out-of-range read forces zeros until the next in-range read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_zero_p1 <= 1'b1;
        end else if (read_pixel_signal) begin
            rd_zero_p1 <= !rd_in_range;
        end
    end

    assign output_data_even_even = rd_zero_p1 ? '0 : rdata_p1[0];
    assign output_data_even_odd  = rd_zero_p1 ? '0 : rdata_p1[1];
    assign output_data_odd_even  = rd_zero_p1 ? '0 : rdata_p1[2];
    assign output_data_odd_odd   = rd_zero_p1 ? '0 : rdata_p1[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= FILL;
            store_count      <= '0;
            l2_seen          <= 1'b0;
            pixel_store_done <= 1'b0;
            write_error      <= 1'b0;
        end else begin
            pixel_store_done <= 1'b0;
            if (write_enable && !wr_ok) begin
                write_error <= 1'b1;
            end
            case (state)
                FILL: begin
                    store_count <= count_next;
                    if (layer2_calculation_done) begin
                        l2_seen <= 1'b1;
                    end
                    // Counting the current write lets a coincident done pulse finish the frame
                    if ((count_next == CNT_W'(FRAME_PIX)) && (layer2_calculation_done || l2_seen)) begin
                        state            <= DONE;
                        pixel_store_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= SERVE;
                end
                SERVE: begin
                    if (layer3_calculation_done) begin
                        state       <= FILL;
                        store_count <= '0;
                        l2_seen     <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer2_pixel_buffer_2x2.sv
// Directed bench for layer2_pixel_buffer_2x2: table of window reads plus
// hand-written fill/done/refill, error, read-before-write and ReLU sequences.
module tb_layer2_pixel_buffer_2x2;
    import cnn_buffer_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  write_enable;
    logic [WORDLENGTH-1:0] write_row;
    logic [WORDLENGTH-1:0] write_col;
    logic [DATA_W-1:0]     write_data;
    logic                  layer2_calculation_done;
    logic                  read_pixel_signal;
    logic [WORDLENGTH-1:0] read_row_addr;
    logic [WORDLENGTH-1:0] read_col_addr;
    logic                  layer3_calculation_done;
    logic [DATA_W-1:0]     ee, eo, oe, oo;
    logic                  pixel_store_done;
    logic                  write_error;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    layer2_pixel_buffer_2x2 #(.IN_DIM(16)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .write_enable            (write_enable),
        .write_row               (write_row),
        .write_col               (write_col),
        .write_data              (write_data),
        .layer2_calculation_done (layer2_calculation_done),
        .read_pixel_signal       (read_pixel_signal),
        .read_row_addr           (read_row_addr),
        .read_col_addr           (read_col_addr),
        .layer3_calculation_done (layer3_calculation_done),
        .output_data_even_even   (ee),
        .output_data_even_odd    (eo),
        .output_data_odd_even    (oe),
        .output_data_odd_odd     (oo),
        .pixel_store_done        (pixel_store_done),
        .write_error             (write_error)
    );

    typedef struct {
        logic [15:0] r;
        logic [15:0] c;
        logic [15:0] x_ee;
        logic [15:0] x_eo;
        logic [15:0] x_oe;
        logic [15:0] x_oo;
    } rd_vec_t;

    rd_vec_t vecs [6];

    function automatic logic [DATA_W-1:0] rep(input logic [15:0] v);
        return {CH_N{v}};
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] row, input logic [15:0] col, input logic [DATA_W-1:0] d);
        write_enable = 1'b1;
        write_row    = row;
        write_col    = col;
        write_data   = d;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [15:0] r, input logic [15:0] c);
        read_pixel_signal = 1'b1;
        read_row_addr     = r;
        read_col_addr     = c;
        tick();
        read_pixel_signal = 1'b0;
    endtask

    // Row-major writes of {8{base + row*16 + col}}; optional done pulse with the last write
    task automatic fill(input logic [15:0] base, input int n, input bit done_on_last);
        for (int i = 0; i < n; i++) begin
            write_enable            = 1'b1;
            write_row               = 16'(i / 16);
            write_col               = 16'(i % 16);
            write_data              = rep(base + 16'(i));
            layer2_calculation_done = done_on_last && (i == n - 1);
            tick();
        end
        write_enable            = 1'b0;
        layer2_calculation_done = 1'b0;
    endtask

    task automatic pulse_l3();
        layer3_calculation_done = 1'b1;
        tick();
        layer3_calculation_done = 1'b0;
    endtask

    logic [DATA_W-1:0] v1, v1_exp, v2;

    initial begin
        vecs[0] = '{16'd3, 16'd5, 16'h006A, 16'h006B, 16'h007A, 16'h007B};
        vecs[1] = '{16'd0, 16'd0, 16'h0000, 16'h0001, 16'h0010, 16'h0011};
        vecs[2] = '{16'd7, 16'd7, 16'h00EE, 16'h00EF, 16'h00FE, 16'h00FF};
        vecs[3] = '{16'd2, 16'd6, 16'h004C, 16'h004D, 16'h005C, 16'h005D};
        vecs[4] = '{16'd8, 16'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[5] = '{16'd0, 16'd8, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

        rst                     = 1'b0;
        write_enable            = 1'b0;
        write_row               = '0;
        write_col               = '0;
        write_data              = '0;
        layer2_calculation_done = 1'b0;
        read_pixel_signal       = 1'b0;
        read_row_addr           = '0;
        read_col_addr           = '0;
        layer3_calculation_done = 1'b0;
        tick();
        tick();
        chk("reset_ee", ee, '0);
        chk("reset_oo", oo, '0);
        chk("reset_done", DATA_W'(pixel_store_done), '0);
        chk("reset_err", DATA_W'(write_error), '0);
        rst = 1'b1;
        tick();

        // Full frame without done pulse: no completion yet
        fill(16'h0000, 256, 1'b0);
        chk("full_no_l2done", DATA_W'(pixel_store_done), '0);
        layer2_calculation_done = 1'b1;
        tick();
        layer2_calculation_done = 1'b0;
        chk("store_done_pulse", DATA_W'(pixel_store_done), 1);
        tick();
        chk("store_done_one_cycle", DATA_W'(pixel_store_done), '0);

        for (int i = 0; i < 6; i++) begin
            rd(vecs[i].r, vecs[i].c);
            chk($sformatf("vec%0d_ee", i), ee, rep(vecs[i].x_ee));
            chk($sformatf("vec%0d_eo", i), eo, rep(vecs[i].x_eo));
            chk($sformatf("vec%0d_oe", i), oe, rep(vecs[i].x_oe));
            chk($sformatf("vec%0d_oo", i), oo, rep(vecs[i].x_oo));
        end

        // Hold: outputs keep last value while read_pixel_signal is low
        rd(16'd3, 16'd5);
        read_row_addr = 16'd8;
        tick();
        chk("hold_data", ee, rep(16'h006A));
        rd(16'd8, 16'd0);
        read_row_addr = 16'd3;
        read_col_addr = 16'd5;
        tick();
        chk("hold_zero", oo, '0);

        // Write while serving is dropped and flagged
        chk("err_before", DATA_W'(write_error), '0);
        wr(16'd6, 16'd10, rep(16'hAAAA));
        chk("err_serve_write", DATA_W'(write_error), 1);
        rd(16'd3, 16'd5);
        chk("serve_write_dropped", ee, rep(16'h006A));

        // Refill with 255 writes, early done pulse latched
        pulse_l3();
        fill(16'h1000, 255, 1'b0);
        layer2_calculation_done = 1'b1;
        tick();
        layer2_calculation_done = 1'b0;
        chk("partial_no_done", DATA_W'(pixel_store_done), '0);
        tick();
        chk("partial_no_done2", DATA_W'(pixel_store_done), '0);
        wr(16'd15, 16'd15, rep(16'h10FF));
        chk("latched_done_pulse", DATA_W'(pixel_store_done), 1);
        tick();
        chk("latched_done_clear", DATA_W'(pixel_store_done), '0);
        rd(16'd7, 16'd7);
        chk("refill_ee", ee, rep(16'h10EE));
        chk("refill_oo", oo, rep(16'h10FF));

        // Done pulse coincident with the last write
        pulse_l3();
        fill(16'h2000, 256, 1'b1);
        chk("coincident_done", DATA_W'(pixel_store_done), 1);
        tick();
        rd(16'd1, 16'd2);
        chk("frame3_ee", ee, rep(16'h2024));
        chk("frame3_oo", oo, rep(16'h2035));

        // Read-before-write and ReLU behaviour on pixel (0,0)
        pulse_l3();
        v1 = '0;
        v1[15:0]  = 16'h8001;
        v1[31:16] = 16'h7FFF;
        v1_exp = v1;
`ifdef BUFFER_RELU_EN
        v1_exp[15:0] = 16'h0000;
`endif
        v2 = rep(16'h0123);
        wr(16'd0, 16'd0, v1);
        write_enable      = 1'b1;
        write_row         = 16'd0;
        write_col         = 16'd0;
        write_data        = v2;
        read_pixel_signal = 1'b1;
        read_row_addr     = 16'd0;
        read_col_addr     = 16'd0;
        tick();
        write_enable      = 1'b0;
        read_pixel_signal = 1'b0;
        chk("relu_and_rbw_old", ee, v1_exp);
        chk("rbw_eo_neighbour", eo, rep(16'h2001));
        rd(16'd0, 16'd0);
        chk("rbw_new", ee, v2);

        // Mid-frame reset, then an out-of-range write in FILL
        rst = 1'b0;
        tick();
        chk("midreset_err", DATA_W'(write_error), '0);
        chk("midreset_out", ee, '0);
        rst = 1'b1;
        tick();
        wr(16'd16, 16'd0, rep(16'h5555));
        chk("err_row_range", DATA_W'(write_error), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
